// File: rtl/pong_paddle_engine.sv
// Pong paddle controller: manual/auto direction, slow-to-fast stepping,
// recentre, and a registered paddle draw strobe.
module pong_paddle_engine #(
    parameter int c_COORD_WIDTH        = 6,
    parameter int c_PADDLE_X_POSITION  = 0,
    parameter int c_PADDLE_WIDTH       = 1,
    parameter int c_PADDLE_HEIGHT      = 6,
    parameter int c_GAME_WINDOW_HEIGHT = 30,
    parameter int c_SLOW_CYCLES        = 1250000,
    parameter int c_FAST_CYCLES        = 625000,
    parameter int c_ACCEL_STEPS        = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Enable,
    input  logic                     i_Mode,
    input  logic                     i_Center,
    input  logic                     i_Paddle_Up,
    input  logic                     i_Paddle_Down,
    input  logic [c_COORD_WIDTH-1:0] i_Ball_Y,
    input  logic [c_COORD_WIDTH-1:0] i_ColCount_Div,
    input  logic [c_COORD_WIDTH-1:0] i_RowCount_Div,
    output logic                     o_DrawPaddle,
    output logic [c_COORD_WIDTH-1:0] o_Paddle_Y_position,
    output logic [1:0]               o_Moving
);

    localparam int CW    = c_COORD_WIDTH;
    localparam int Y_MAX = c_GAME_WINDOW_HEIGHT - c_PADDLE_HEIGHT;
    localparam int Y_MID = Y_MAX / 2;
    localparam int CNT_W = $clog2(c_SLOW_CYCLES);
    localparam int ACC_W = $clog2(c_ACCEL_STEPS + 1);

    localparam logic [CW-1:0]    Y_MAX_C   = CW'(Y_MAX);
    localparam logic [CW-1:0]    Y_MID_C   = CW'(Y_MID);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(c_SLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(c_FAST_CYCLES - 1);
    localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(c_ACCEL_STEPS - 1);
    localparam logic [CW:0]      HALF_H    = (CW+1)'(c_PADDLE_HEIGHT / 2);
    localparam logic [CW:0]      SPAN_H    = (CW+1)'(c_PADDLE_HEIGHT - 1);
    localparam logic [CW:0]      COL_LO    = (CW+1)'(c_PADDLE_X_POSITION);
    localparam logic [CW:0]      COL_HI    =
        (CW+1)'(c_PADDLE_X_POSITION + c_PADDLE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SLOW,
        FAST
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    state_t            state;
    dir_t              dir;
    dir_t              req;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_last;
    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     y;
    logic [CW-1:0]     y_step;
    logic [CW:0]       center;
    logic [CW:0]       ball;
    logic [CW:0]       row_lo;
    logic [CW:0]       row_hi;
    logic [CW:0]       col;
    logic [CW:0]       row;

    assign o_Paddle_Y_position = y;

    always_comb begin
        center = {1'b0, y} + HALF_H;
        ball   = {1'b0, i_Ball_Y};
        req    = DIR_NONE;
        if (i_Enable) begin
            if (i_Mode) begin
                if (ball > center)
                    req = DIR_DOWN;
                else if (ball < center)
                    req = DIR_UP;
            end else begin
                case ({i_Paddle_Up, i_Paddle_Down})
                    2'b10:   req = DIR_UP;
                    2'b01:   req = DIR_DOWN;
                    default: req = DIR_NONE;
                endcase
            end
        end
    end

    // A blocked step still consumes its interval; only Y is clamped.
    always_comb begin
        cnt_last = (state == FAST) ? FAST_LAST : SLOW_LAST;
        y_step   = y;
        if (dir == DIR_DOWN && y != Y_MAX_C)
            y_step = y + 1'b1;
        else if (dir == DIR_UP && y != '0)
            y_step = y - 1'b1;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            y        <= Y_MID_C;
            state    <= IDLE;
            dir      <= DIR_NONE;
            cnt      <= '0;
            acc      <= '0;
            o_Moving <= 2'b00;
        end else if (i_Center) begin
            y        <= Y_MID_C;
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            o_Moving <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req != DIR_NONE) begin
                        dir      <= req;
                        state    <= SLOW;
                        cnt      <= CNT_W'(1);
                        acc      <= '0;
                        o_Moving <= 2'b01;
                    end
                end
                SLOW, FAST: begin
                    if (req != dir) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        acc      <= '0;
                        o_Moving <= 2'b00;
                    end else if (cnt == cnt_last) begin
                        cnt <= '0;
                        y   <= y_step;
                        if (state == SLOW) begin
                            acc <= acc + 1'b1;
                            if (acc == ACC_LAST) begin
                                state    <= FAST;
                                o_Moving <= 2'b11;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    acc      <= '0;
                    o_Moving <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        col    = {1'b0, i_ColCount_Div};
        row    = {1'b0, i_RowCount_Div};
        row_lo = {1'b0, y};
        row_hi = {1'b0, y} + SPAN_H;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            o_DrawPaddle <= 1'b0;
        else
            o_DrawPaddle <= (col >= COL_LO) && (col <= COL_HI) &&
                            (row >= row_lo) && (row <= row_hi);
    end

endmodule

// File: doc/pong_paddle_engine.md
Name: pong_paddle_engine

Overview:
Parametrised paddle controller for the pong game. It is the successor of the single-speed paddle controller and generalises coordinate width, paddle width and height, and step timing. It adds hold-to-accelerate, an automatic ball-tracking mode and a synchronous recentre. It sits between the input debouncers/ball logic and the pixel mux, and outputs the paddle position plus a registered draw strobe.

Parameters:
c_COORD_WIDTH, 6, bit width of all tile coordinates.
c_PADDLE_X_POSITION, 0, leftmost tile column of the paddle.
c_PADDLE_WIDTH, 1, paddle width in tile columns (>=1).
c_PADDLE_HEIGHT, 6, paddle height in tile rows (>=1).
c_GAME_WINDOW_HEIGHT, 30, playfield height in tile rows (> c_PADDLE_HEIGHT).
c_SLOW_CYCLES, 1250000, clocks per step in slow speed (50 ms at 25 MHz, >=2).
c_FAST_CYCLES, 625000, clocks per step in fast speed (>=2, <= c_SLOW_CYCLES).
c_ACCEL_STEPS, 4, consecutive same-direction slow steps before switching to fast (>=1).

Ports:
i_Clk  in  1  system clock, 25 MHz.
i_Reset  in  1  asynchronous, active-high reset.
i_Enable  in  1  game running; when low, no movement occurs.
i_Mode  in  1  0 = manual (buttons), 1 = auto (track ball).
i_Center  in  1  synchronous recentre pulse.
i_Paddle_Up  in  1  manual up request.
i_Paddle_Down  in  1  manual down request.
i_Ball_Y  in  c_COORD_WIDTH  ball tile row, used in auto mode.
i_ColCount_Div  in  c_COORD_WIDTH  current tile column.
i_RowCount_Div  in  c_COORD_WIDTH  current tile row.
o_DrawPaddle  out  1  registered: current tile is paddle.
o_Paddle_Y_position  out  c_COORD_WIDTH  top row of paddle.
o_Moving  out  2  {fast, active}: bit0 = state is not IDLE, bit1 = state is FAST.

Behaviour:
- Constants: Y_MAX = c_GAME_WINDOW_HEIGHT - c_PADDLE_HEIGHT; Y_MID = Y_MAX/2 (floor); center = Y + c_PADDLE_HEIGHT/2 (floor).
- Reset (async): Y = Y_MID, o_DrawPaddle = 0, o_Moving = 0, state IDLE, step counter = 0, accel count = 0.
- Direction request, evaluated each cycle:
  - Manual mode: DOWN if Down & !Up; UP if Up & !Down; otherwise NONE.
  - Auto mode: DOWN if i_Ball_Y > center; UP if i_Ball_Y < center; otherwise NONE.
  - Direction is forced to NONE when i_Enable = 0.
- State machine IDLE / SLOW / FAST, with counter cnt and accel count acc:
  - IDLE: a non-NONE direction latches dir, goes to SLOW, sets cnt = 1, acc = 0. No step occurs in this cycle.
  - SLOW/FAST: if request is NONE or differs from the latched dir, go to IDLE and clear cnt and acc. This takes effect the same cycle; a new direction restarts from IDLE on the next cycle.
  - Otherwise, if cnt == interval-1 (interval = c_SLOW_CYCLES in SLOW, c_FAST_CYCLES in FAST), issue a step and set cnt = 0. Otherwise increment cnt.
  - In SLOW, each step increments acc. When a step makes acc == c_ACCEL_STEPS, go to FAST.
- First step therefore lands exactly c_SLOW_CYCLES clocks after the request first appears. Subsequent steps follow at the interval of the current state.
- Step: DOWN gives Y+1 unless Y == Y_MAX; UP gives Y-1 unless Y == 0. At a wall Y holds, but timing and state still advance, so the paddle can reach FAST while pinned. Y never leaves [0, Y_MAX].
- i_Center: Y = Y_MID, state IDLE, cnt = acc = 0. It has priority over any step in the same cycle.
- Mode change mid-move is handled only through the direction-mismatch/NONE rule. No other special case applies.
- Draw: o_DrawPaddle is registered with 1-cycle latency. It is set when col is in [c_PADDLE_X_POSITION, c_PADDLE_X_POSITION + c_PADDLE_WIDTH - 1] and row is in [Y, Y + c_PADDLE_HEIGHT - 1]. Exactly c_PADDLE_HEIGHT rows are drawn. Comparisons use c_COORD_WIDTH+1 bits so there is no overflow.
- cnt width is $clog2(c_SLOW_CYCLES).

Test Plan (SLOW=4, FAST=2, ACCEL=2, H=6, WIN=30, so Y_MAX=24, Y_MID=12):
- Reset asserted mid-move -> immediately Y=12, o_Moving=0, o_DrawPaddle=0. After release, no movement without a request.
- Hold Down from Y=12 for 20 clocks -> steps at cycles 4, 8 (becomes FAST), 10, 12, 14, 16, 18, 20. Y=20, o_Moving=2'b11.
- Hold Up from Y=2 -> Y reaches 0 and stays 0. o_Moving still reaches 2'b11. Then press Up+Down -> o_Moving=0 the next cycle, Y=0.
- Auto mode, Y=12 (center 15), i_Ball_Y=20 -> Y climbs by 1 per step until center == 20 (Y=17), then IDLE. Ball moves to 5 -> Y descends to 2.
- Down held 3 cycles then i_Center with i_Enable=1 -> Y=12, IDLE, no step on the would-be cycle. i_Enable=0 with Down held -> Y unchanged for 100 cycles.
- Draw scan with X=3, WIDTH=2, Y=12 -> o_DrawPaddle=1 one cycle after col in {3,4} and row 12..17. It is 0 at row 18, at col 5 and at row 11.
